load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the byte-banked data memory port; sits between the execute stage and the memory.
//  Accepts one load/store per valid/ready handshake and checks alignment, op legality and address range.
//  Drives the memory's address/wr_data/wr_mask/rd_mask port and returns load data or store completion.
//  Every result leaves on a valid/ready response channel tagged with the destination register.
// PARAMETERS
//  MEM_ADDR_BITS  12  byte-address width backed by memory; a request with any addr bit >= MEM_ADDR_BITS set is a range fault
//  TAG_W          5   width of destination-register tag carried request -> response
// PORTS
//  i_clk                        in   1       clock, rising edge
//  i_reset                      in   1       reset, asynchronous, active-low
//  i_req_valid                  in   1       request valid
//  o_req_ready                  out  1       request ready; high only in IDLE
//  i_req_store                  in   1       1 = store, 0 = load
//  i_req_funct3                 in   3       LB/SB=000 LH/SH=001 LW/SW=010 LBU=100 LHU=101
//  i_req_addr                   in   32      byte address
//  i_req_wdata                  in   32      store data, right-justified
//  i_req_tag                    in   TAG_W   destination register
//  o_mem_address                out  32      to memory address
//  o_mem_wr_data                out  32      to memory write data, passed unmodified
//  o_mem_wr_mask                out  2       N=0 B=1 H=2 W=3
//  o_mem_rd_mask                out  3       W=0 HZ=1 BZ=2 HE=3 BE=4
//  i_mem_rd_data                in   32      memory read data, valid 1 cycle after address is sampled
//  i_mem_err_address_misaligned in   1       memory error flag
//  i_mem_err_invalid_read_mask  in   1       memory error flag
//  o_rsp_valid                  out  1       response valid; held until accepted
//  i_rsp_ready                  in   1       response accept
//  o_rsp_data                   out  32      load result (extended by memory); 0 for stores and errors
//  o_rsp_tag                    out  TAG_W   echoed i_req_tag
//  o_rsp_is_load                out  1       1 if the request was a load
//  o_rsp_err                    out  2       0 none, 1 misaligned, 2 illegal op, 3 range/memory fault
// BEHAVIOUR
//  - Reset: state IDLE; o_mem_wr_mask=0; o_mem_rd_mask=0; o_mem_address, o_mem_wr_data, o_rsp_* and o_rsp_err all 0.
//  - Reset is asynchronous, so it clears o_mem_wr_mask immediately; a store in ISSUE when reset asserts is dropped.
//  - States:
//    - IDLE: handshake fires when i_req_valid & o_req_ready. The request is decoded and registered.
//    - IDLE, error present: go to RESP. No memory access; wr_mask stays 0.
//    - IDLE, load: go to ISSUE.
//    - IDLE, store: go to ISSUE.
//    - ISSUE, 1 cycle: mem outputs are driven. A store sets wr_mask B/H/W; it is committed at the edge ending ISSUE; go to RESP.
//      A load sets rd_mask (LB=BE LH=HE LW=W LBU=BZ LHU=HZ) with wr_mask=0; go to CAPTURE.
//    - CAPTURE: register i_mem_rd_data into o_rsp_data. o_mem_wr_mask=0. Go to RESP.
//    - RESP: o_rsp_valid=1 with stable data, tag and err. On i_rsp_ready, go to IDLE.
//  - Response latency from the accept edge: error 1 cycle, store 2 cycles, load 3 cycles.
//  - o_req_ready is combinational (state==IDLE). A new request is never accepted in the same cycle a response is accepted.
//  - Error priority: illegal > misaligned > range.
//    - illegal: funct3 011/110/111, or a store with funct3[2]=1.
//    - misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
//  - Outside ISSUE, o_mem_wr_mask is always 0. o_mem_rd_mask and o_mem_address hold their last value.
//  - Memory wraps low address bits; range fault prevents aliasing writes.
// CONFIGURATION
//  LSU_MEM_ERR_EN
//    - defined: both memory error flags are sampled in the cycle after ISSUE. If o_rsp_err is still 0 it becomes 3.
//    - undefined: the flags are ignored. The ports remain.
// STRUCTURE
//  - Package argon_mem_pkg holds:
//    - WRMASK_N/B/H/W and RDMASK_W/HZ/BZ/HE/BE constants
//    - lsu_state_e {IDLE, ISSUE, CAPTURE, RESP}
//    - lsu_err_e
//    - funct3 localparams
//  - One combinational sub-module, lsu_req_decode: maps funct3/store/addr to wr_mask, rd_mask and err.
// TESTING
//  - SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store rsp after 2 cycles (err 0); load rsp after 3 cycles, data 0xDEADBEEF.
//  - SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
//  - LH 0x21 -> err 1, 1 cycle, wr_mask stays 0; SW 0x22 -> err 1, memory word unchanged.
//  - funct3=011 load; SB addr 0x1000 -> err 2, then err 3; no memory write occurs.
//  - Hold i_rsp_ready=0 for 5 cycles on a load -> o_rsp_* stable, o_req_ready=0. Drop i_reset during ISSUE of an SW -> target word unchanged, all outputs 0.
//  - With LSU_MEM_ERR_EN, force i_mem_err_invalid_read_mask during a load -> err 3; without it -> err 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Package argon_mem_pkg: shared definitions for the load/store unit and the
// byte-banked data memory port.
//   - WRMASK_* : memory write-mask encodings (N/B/H/W)
//   - RDMASK_* : memory read-mask encodings (W/HZ/BZ/HE/BE)
//   - F3_*     : RISC-V style funct3 load/store size codes
//   - lsu_state_e : load/store unit FSM states
//   - lsu_err_e   : response error codes
package argon_mem_pkg;

    localparam logic [1:0] WRMASK_N = 2'd0;
    localparam logic [1:0] WRMASK_B = 2'd1;
    localparam logic [1:0] WRMASK_H = 2'd2;
    localparam logic [1:0] WRMASK_W = 2'd3;

    localparam logic [2:0] RDMASK_W  = 3'd0;
    localparam logic [2:0] RDMASK_HZ = 3'd1;
    localparam logic [2:0] RDMASK_BZ = 3'd2;
    localparam logic [2:0] RDMASK_HE = 3'd3;
    localparam logic [2:0] RDMASK_BE = 3'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_ILLEGAL    = 2'd2,
        ERR_FAULT      = 2'd3
    } lsu_err_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Interface load_store_unit_if: request and response channels between the
// execute stage (master) and the load/store unit (slave).
//   Request : i_req_valid, o_req_ready, i_req_store, i_req_funct3,
//             i_req_addr, i_req_wdata, i_req_tag
//   Response: o_rsp_valid, i_rsp_ready, o_rsp_data, o_rsp_tag,
//             o_rsp_is_load, o_rsp_err
// Signal names carry the direction as seen from the load/store unit.
interface load_store_unit_if #(
    parameter int TAG_W = 5
) ();
    logic             i_req_valid;
    logic             o_req_ready;
    logic             i_req_store;
    logic [2:0]       i_req_funct3;
    logic [31:0]      i_req_addr;
    logic [31:0]      i_req_wdata;
    logic [TAG_W-1:0] i_req_tag;

    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [31:0]      o_rsp_data;
    logic [TAG_W-1:0] o_rsp_tag;
    logic             o_rsp_is_load;
    logic [1:0]       o_rsp_err;

    modport master (
        output i_req_valid, i_req_store, i_req_funct3, i_req_addr,
               i_req_wdata, i_req_tag, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_tag,
               o_rsp_is_load, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_store, i_req_funct3, i_req_addr,
               i_req_wdata, i_req_tag, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_tag,
               o_rsp_is_load, o_rsp_err
    );
endinterface

// File: rtl/load_store_unit_req_decode.sv
// Module lsu_req_decode: combinational request decoder.
//   i_store   in  1   1 = store, 0 = load
//   i_funct3  in  3   size / extension code
//   i_addr    in  32  byte address
//   o_wr_mask out 2   memory write mask for a store
//   o_rd_mask out 3   memory read mask for a load
//   o_err     out 2   error code, priority illegal > misaligned > range
module lsu_req_decode
    import argon_mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    output logic [1:0]  o_wr_mask,
    output logic [2:0]  o_rd_mask,
    output lsu_err_e    o_err
);
    logic w_illegal;
    logic w_misaligned;
    logic w_range;

    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        o_wr_mask    = WRMASK_N;
        o_rd_mask    = RDMASK_W;
        case (i_funct3)
            F3_B: begin
                o_wr_mask = WRMASK_B;
                o_rd_mask = RDMASK_BE;
            end
            F3_H: begin
                o_wr_mask    = WRMASK_H;
                o_rd_mask    = RDMASK_HE;
                w_misaligned = i_addr[0];
            end
            F3_W: begin
                o_wr_mask    = WRMASK_W;
                o_rd_mask    = RDMASK_W;
                w_misaligned = |i_addr[1:0];
            end
            F3_BU: begin
                o_rd_mask = RDMASK_BZ;
                w_illegal = i_store;
            end
            F3_HU: begin
                o_rd_mask    = RDMASK_HZ;
                w_illegal    = i_store;
                w_misaligned = i_addr[0];
            end
            default: w_illegal = 1'b1;
        endcase

        // Any address bit at or above the backed width would alias after the
        // memory wraps its low bits.
        w_range = |(i_addr >> MEM_ADDR_BITS);

        if (w_illegal)         o_err = ERR_ILLEGAL;
        else if (w_misaligned) o_err = ERR_MISALIGNED;
        else if (w_range)      o_err = ERR_FAULT;
        else                   o_err = ERR_NONE;
    end
endmodule

// File: rtl/load_store_unit.sv
// Module load_store_unit: CPU-side initiator for the byte-banked data memory.
// Accepts one load/store per handshake, checks it, drives the memory port and
// returns a tagged response.
//   i_clk, i_reset (async, active-low)
//   lsu             request/response channels (load_store_unit_if.slave)
//   o_mem_address   memory byte address
//   o_mem_wr_data   store data, unmodified
//   o_mem_wr_mask   write mask, non-zero only in ISSUE of a store
//   o_mem_rd_mask   read mask, holds last load's value
//   i_mem_rd_data   read data, valid the cycle after the address is sampled
//   i_mem_err_*     memory error flags
// Build option LSU_MEM_ERR_EN: when defined, the memory error flags seen in
// the cycle after ISSUE turn an error-free load into a fault (err 3).
module load_store_unit
    import argon_mem_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12,
    parameter int TAG_W         = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    load_store_unit_if.slave    lsu,
    output logic [31:0]         o_mem_address,
    output logic [31:0]         o_mem_wr_data,
    output logic [1:0]          o_mem_wr_mask,
    output logic [2:0]          o_mem_rd_mask,
    input  logic [31:0]         i_mem_rd_data,
    input  logic                i_mem_err_address_misaligned,
    input  logic                i_mem_err_invalid_read_mask
);
    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;
    logic             w_accept;
    logic [1:0]       w_dec_wr_mask;
    logic [2:0]       w_dec_rd_mask;
    lsu_err_e         w_dec_err;
    logic             w_mem_err;

    logic             r_is_load;
    lsu_err_e         r_err;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;

    lsu_req_decode #(
        .MEM_ADDR_BITS (MEM_ADDR_BITS)
    ) u_decode (
        .i_store   (lsu.i_req_store),
        .i_funct3  (lsu.i_req_funct3),
        .i_addr    (lsu.i_req_addr),
        .o_wr_mask (w_dec_wr_mask),
        .o_rd_mask (w_dec_rd_mask),
        .o_err     (w_dec_err)
    );

`ifdef LSU_MEM_ERR_EN
    assign w_mem_err = i_mem_err_address_misaligned | i_mem_err_invalid_read_mask;
`else
    logic w_unused;
    assign w_unused  = i_mem_err_address_misaligned ^ i_mem_err_invalid_read_mask;
    assign w_mem_err = 1'b0;
`endif

    assign w_accept        = lsu.i_req_valid && (r_state == IDLE);
    assign lsu.o_req_ready = (r_state == IDLE);
    assign lsu.o_rsp_valid = (r_state == RESP);
    assign lsu.o_rsp_data    = r_data;
    assign lsu.o_rsp_tag     = r_tag;
    assign lsu.o_rsp_is_load = r_is_load;
    assign lsu.o_rsp_err     = r_err;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_dec_err != ERR_NONE) ? RESP : ISSUE;
            ISSUE:   w_state_nxt = r_is_load ? CAPTURE : RESP;
            CAPTURE: w_state_nxt = RESP;
            RESP:    if (lsu.i_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory outputs are loaded at the accept edge so they are already valid
    // for the whole ISSUE cycle; the write mask drops at the edge ending ISSUE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_mem_address <= '0;
            o_mem_wr_data <= '0;
            o_mem_wr_mask <= WRMASK_N;
            o_mem_rd_mask <= RDMASK_W;
            r_is_load     <= 1'b0;
            r_err         <= ERR_NONE;
            r_tag         <= '0;
            r_data        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tag     <= lsu.i_req_tag;
                        r_is_load <= !lsu.i_req_store;
                        r_err     <= w_dec_err;
                        r_data    <= '0;
                        if (w_dec_err == ERR_NONE) begin
                            o_mem_address <= lsu.i_req_addr;
                            if (lsu.i_req_store) begin
                                o_mem_wr_data <= lsu.i_req_wdata;
                                o_mem_wr_mask <= w_dec_wr_mask;
                            end else begin
                                o_mem_rd_mask <= w_dec_rd_mask;
                            end
                        end
                    end
                end
                ISSUE: o_mem_wr_mask <= WRMASK_N;
                CAPTURE: begin
                    // Only loads reach here, and only error-free ones.
                    if (w_mem_err) begin
                        r_err  <= ERR_FAULT;
                        r_data <= '0;
                    end else begin
                        r_data <= i_mem_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
